rs_wakeup_select: RTL

Reservation-station array that sits directly downstream of the dispatch scoreboard. It holds up to ENT_NUM dispatched instructions with their per-source wakeup state (match bit, latency shift register, producer delay pattern). Each cycle it advances that state on destination-tag broadcasts, selects one ready entry, and issues it to a functional unit. The issued destination tag is driven out as a broadcast, which is fed back to every wakeup consumer.

---
 rtl/rs_wakeup_select.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rs_wakeup_select.sv
// Reservation station that tracks per-source wakeup state for dispatched instructions.
// Each cycle it issues the lowest-index ready entry and reflects that issue as a tag broadcast.
module rs_wakeup_select #(
  parameter int ENT_NUM = 8,
  parameter int PREG_W  = 6,
  parameter int LAT_W   = 4,
  parameter int PAY_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              dispatch_ready,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic [PREG_W-1:0] src1_1,
  input  logic [PREG_W-1:0] src2_1,
  input  logic [PREG_W-1:0] src1_2,
  input  logic [PREG_W-1:0] src2_2,
  input  logic              match1_1,
  input  logic              match2_1,
  input  logic              match1_2,
  input  logic              match2_2,
  input  logic [LAT_W-1:0]  shift_r1_1,
  input  logic [LAT_W-1:0]  shift_r2_1,
  input  logic [LAT_W-1:0]  shift_r1_2,
  input  logic [LAT_W-1:0]  shift_r2_2,
  input  logic [LAT_W-1:0]  delay1_1,
  input  logic [LAT_W-1:0]  delay2_1,
  input  logic [LAT_W-1:0]  delay1_2,
  input  logic [LAT_W-1:0]  delay2_2,
  input  logic [PREG_W-1:0] dst_1,
  input  logic [PREG_W-1:0] dst_2,
  input  logic              wr_reg_1,
  input  logic              wr_reg_2,
  input  logic [PAY_W-1:0]  payload_1,
  input  logic [PAY_W-1:0]  payload_2,
  input  logic              broadcast_enable1,
  input  logic              broadcast_enable2,
  input  logic              broadcast_enable3,
  input  logic [PREG_W-1:0] broadcast_tag1,
  input  logic [PREG_W-1:0] broadcast_tag2,
  input  logic [PREG_W-1:0] broadcast_tag3,
  input  logic              issue_stall,
  output logic              issue_valid,
  output logic [PREG_W-1:0] issue_dst,
  output logic              issue_wr_reg,
  output logic [PAY_W-1:0]  issue_payload,
  output logic              bcast_enable,
  output logic [PREG_W-1:0] bcast_tag
);
  localparam int IDX_W = $clog2(ENT_NUM);

  logic [ENT_NUM-1:0] r_valid;
  logic [ENT_NUM-1:0] r_wr_reg;
  logic [PREG_W-1:0]  r_dst   [ENT_NUM];
  logic [PAY_W-1:0]   r_pay   [ENT_NUM];
  logic [PREG_W-1:0]  r_tag   [ENT_NUM][2];
  logic               r_match [ENT_NUM][2];
  logic [LAT_W-1:0]   r_shift [ENT_NUM][2];
  logic [LAT_W-1:0]   r_delay [ENT_NUM][2];

  logic               r_issue_valid;
  logic [PREG_W-1:0]  r_issue_dst;
  logic               r_issue_wr_reg;
  logic [PAY_W-1:0]   r_issue_pay;

  logic [PREG_W-1:0]  w_d_tag   [2][2];
  logic               w_d_match [2][2];
  logic [LAT_W-1:0]   w_d_shift [2][2];
  logic [LAT_W-1:0]   w_d_delay [2][2];
  logic [PREG_W-1:0]  w_d_dst   [2];
  logic               w_d_wr    [2];
  logic [PAY_W-1:0]   w_d_pay   [2];

  // Dispatch ports gathered as [port][source] so the write loop stays uniform.
  assign w_d_tag[0][0]   = src1_1;     assign w_d_tag[0][1]   = src2_1;
  assign w_d_tag[1][0]   = src1_2;     assign w_d_tag[1][1]   = src2_2;
  assign w_d_match[0][0] = match1_1;   assign w_d_match[0][1] = match2_1;
  assign w_d_match[1][0] = match1_2;   assign w_d_match[1][1] = match2_2;
  assign w_d_shift[0][0] = shift_r1_1; assign w_d_shift[0][1] = shift_r2_1;
  assign w_d_shift[1][0] = shift_r1_2; assign w_d_shift[1][1] = shift_r2_2;
  assign w_d_delay[0][0] = delay1_1;   assign w_d_delay[0][1] = delay2_1;
  assign w_d_delay[1][0] = delay1_2;   assign w_d_delay[1][1] = delay2_2;
  assign w_d_dst[0] = dst_1;     assign w_d_dst[1] = dst_2;
  assign w_d_wr[0]  = wr_reg_1;  assign w_d_wr[1]  = wr_reg_2;
  assign w_d_pay[0] = payload_1; assign w_d_pay[1] = payload_2;

  logic             w_found0, w_found1;
  logic [IDX_W-1:0] w_alloc0, w_alloc1;

  always_comb begin
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_alloc0 = '0;
    w_alloc1 = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!r_valid[i]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_alloc0 = IDX_W'(i);
        end else if (!w_found1) begin
          w_found1 = 1'b1;
          w_alloc1 = IDX_W'(i);
        end
      end
    end
  end

  assign dispatch_ready = w_found1;

  logic             w_wr_en  [2];
  logic [IDX_W-1:0] w_wr_idx [2];

  assign w_wr_en[0]  = valid_1 && dispatch_ready;
  assign w_wr_idx[0] = w_alloc0;
  assign w_wr_en[1]  = valid_2 && dispatch_ready;
  assign w_wr_idx[1] = valid_1 ? w_alloc1 : w_alloc0;

  logic               w_hit [ENT_NUM][2];
  logic [ENT_NUM-1:0] w_ready;

  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) begin
      w_ready[i] = r_valid[i] && r_shift[i][0][0] && r_shift[i][1][0];
      for (int s = 0; s < 2; s++) begin
        w_hit[i][s] = (broadcast_enable1 && (broadcast_tag1 == r_tag[i][s])) ||
                      (broadcast_enable2 && (broadcast_tag2 == r_tag[i][s])) ||
                      (broadcast_enable3 && (broadcast_tag3 == r_tag[i][s]));
      end
    end
  end

  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (w_ready[i] && !w_sel_found) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  // Dispatch writes land in slots that were free before the edge, so they never collide with wakeup or select.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid        <= '0;
      r_issue_valid  <= 1'b0;
      r_issue_dst    <= '0;
      r_issue_wr_reg <= 1'b0;
      r_issue_pay    <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_valid[i]) begin
            if (w_hit[i][s]) begin
              r_match[i][s] <= 1'b1;
              r_shift[i][s] <= r_delay[i][s];
            end else if (r_match[i][s] && !r_shift[i][s][0]) begin
              r_shift[i][s] <= {r_shift[i][s][LAT_W-1], r_shift[i][s][LAT_W-1:1]};
            end
          end
        end
      end

      if (w_sel_found && !issue_stall) begin
        r_valid[w_sel_idx] <= 1'b0;
        r_issue_valid      <= 1'b1;
        r_issue_dst        <= r_dst[w_sel_idx];
        r_issue_wr_reg     <= r_wr_reg[w_sel_idx];
        r_issue_pay        <= r_pay[w_sel_idx];
      end else begin
        r_issue_valid <= 1'b0;
      end

      for (int p = 0; p < 2; p++) begin
        if (w_wr_en[p]) begin
          r_valid[w_wr_idx[p]]  <= 1'b1;
          r_dst[w_wr_idx[p]]    <= w_d_dst[p];
          r_wr_reg[w_wr_idx[p]] <= w_d_wr[p];
          r_pay[w_wr_idx[p]]    <= w_d_pay[p];
          for (int s = 0; s < 2; s++) begin
            r_tag[w_wr_idx[p]][s]   <= w_d_tag[p][s];
            r_match[w_wr_idx[p]][s] <= w_d_match[p][s];
            r_shift[w_wr_idx[p]][s] <= w_d_shift[p][s];
            r_delay[w_wr_idx[p]][s] <= w_d_delay[p][s];
          end
        end
      end
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_dst     = r_issue_dst;
  assign issue_wr_reg  = r_issue_wr_reg;
  assign issue_payload = r_issue_pay;
  assign bcast_enable  = r_issue_valid && r_issue_wr_reg;
  assign bcast_tag     = r_issue_dst;
endmodule
